// File: rtl/prefetch_queue_if.sv
// Signal bundle between the prefetch queue, byte-wide memory and the execution unit.
// The master modport is the prefetch queue itself; the slave modport is its environment.
interface prefetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic [ADDR_W-1:0] new_pc;

  // mem_req/mem_addr stay stable until a one-cycle mem_ack returns mem_data; the head byte
  // moves to the EU on any clock edge where q_valid & q_ready, and flush overrides both.
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  logic              q_valid;
  logic [7:0]        q_data;
  logic [ADDR_W-1:0] q_pc;
  logic              q_ready;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        dbg_state;

  modport master (
    input  flush, new_pc, mem_ack, mem_data, q_ready,
    output mem_req, mem_addr, q_valid, q_data, q_pc, q_count, fetch_pc, dbg_state
  );

  modport slave (
    output flush, new_pc, mem_ack, mem_data, q_ready,
    input  mem_req, mem_addr, q_valid, q_data, q_pc, q_count, fetch_pc, dbg_state
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch byte queue: fetches opcode bytes one at a time over req/ack and
// presents the head byte with its address to the execution unit; flush redirects fetch.
module prefetch_queue #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  prefetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        data_q [DEPTH];
  logic [7:0]        data_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push       = (state_q == FETCH) && bus.mem_ack && !bus.flush;
    pop        = (count_q != '0) && bus.q_ready && !bus.flush;
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    data_d     = data_q;
    pc_d       = pc_q;

    // Each byte keeps the address it was fetched from, so q_pc survives flushes and wrap.
    if (push) begin
      data_d[tail_q] = bus.mem_data;
      pc_d[tail_q]   = mem_addr_q;
      tail_d         = next_ptr(tail_q);
      fetch_pc_d     = mem_addr_q + 1'b1;
    end
    if (pop) begin
      head_d = next_ptr(head_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (bus.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.new_pc;
    end

    // A request only leaves IDLE with a free slot, so the returning byte always fits.
    case (state_q)
      IDLE: begin
        if (!bus.flush && (count_q < CNT_W'(DEPTH))) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= RESET_PC;
      end
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.fetch_pc  = fetch_pc_q;
  assign bus.q_count   = count_q;
  assign bus.q_valid   = (count_q != '0);
  assign bus.q_data    = data_q[head_q];
  assign bus.q_pc      = pc_q[head_q];
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a memory responder returns the low address byte,
// and scoreboards check popped bytes and issued fetch addresses against expected queues.
module tb_prefetch_queue;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 6;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   ack_delay = 1;

  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W+7:0] mon_e;
  logic [ADDR_W-1:0] mon_a;
  logic              prev_req;

  prefetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

  prefetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_full_idle(input string name);
    int n = 0;
    while (!(bus.q_count == 3'd6 && !bus.mem_req && bus.dbg_state == S_IDLE) && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  task automatic drain_exp(input string name);
    int n = 0;
    bus.q_ready = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    bus.q_ready = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory: acks ack_delay cycles after it first sees mem_req, returning the low address byte.
  initial begin : mem_model
    int cnt;
    logic busy;
    logic [ADDR_W-1:0] addr;
    cnt = 0;
    busy = 1'b0;
    addr = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    forever begin
      tick();
      bus.mem_ack = 1'b0;
      if (!rst) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt <= 1) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = addr[7:0];
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.mem_req) begin
        busy = 1'b1;
        cnt  = ack_delay;
        addr = bus.mem_addr;
      end
    end
  end

  // Monitor: popped bytes and rising-edge fetch requests, checked mid-cycle.
  initial begin : monitor
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.q_valid && bus.q_ready && !bus.flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected actual=%0h:%0h required=none", bus.q_pc, bus.q_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.q_pc, bus.q_data} !== mon_e) begin
            failures++;
            $display("FAIL pop_byte actual=%0h:%0h required=%0h:%0h",
                     bus.q_pc, bus.q_data, mon_e[ADDR_W+7:8], mon_e[7:0]);
          end
        end
      end
      if (rst && bus.mem_req && !prev_req && exp_addr_q.size() != 0) begin
        mon_a = exp_addr_q.pop_front();
        checks++;
        if (bus.mem_addr !== mon_a) begin
          failures++;
          $display("FAIL req_addr actual=%0h required=%0h", bus.mem_addr, mon_a);
        end
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    bus.flush   = 1'b0;
    bus.new_pc  = '0;
    bus.q_ready = 1'b0;
    rst = 1'b0;

    // 1. Reset values, then fill to capacity.
    tick();
    tick();
    chk("rst_mem_req",  32'(bus.mem_req),   32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr),  32'h0000);
    chk("rst_fetch_pc", 32'(bus.fetch_pc),  32'h0000);
    chk("rst_q_count",  32'(bus.q_count),   32'd0);
    chk("rst_q_valid",  32'(bus.q_valid),   32'd0);
    chk("rst_q_data",   32'(bus.q_data),    32'h00);
    chk("rst_q_pc",     32'(bus.q_pc),      32'h0000);
    chk("rst_state",    32'(bus.dbg_state), 32'(S_IDLE));
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(16'(i));
      exp_q.push_back({16'(i), 8'(i)});
    end
    rst = 1'b1;
    wait_full_idle("fill_full");
    chk("fill_q_data",   32'(bus.q_data),   32'h00);
    chk("fill_q_pc",     32'(bus.q_pc),     32'h0000);
    chk("fill_fetch_pc", 32'(bus.fetch_pc), 32'h0006);
    chk("fill_addrs",    32'(exp_addr_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_req", 32'(bus.mem_req), 32'd0);
    end

    // 2. Stream 20 bytes with the EU always ready.
    for (int i = 6; i < 20; i++) begin
      exp_addr_q.push_back(16'(i));
      exp_q.push_back({16'(i), 8'(i)});
    end
    drain_exp("stream_done");
    chk("stream_addrs", 32'(exp_addr_q.size()), 32'd0);

    // 3. Flush while a slow fetch is outstanding.
    ack_delay = 3;
    wait_full_idle("t3_full");
    exp_q.push_back({16'h0014, 8'h14});
    exp_addr_q.push_back(16'h001A);
    exp_addr_q.push_back(16'h1234);
    bus.q_ready = 1'b1;
    tick();
    bus.q_ready = 1'b0;
    chk("t3_pop_one", 32'(exp_q.size()), 32'd0);
    n = 0;
    while (!bus.mem_req && n < 50) begin
      tick();
      n++;
    end
    chk("t3_req_rise", 32'(bus.mem_req), 32'd1);
    tick();
    bus.flush  = 1'b1;
    bus.new_pc = 16'h1234;
    tick();
    bus.flush = 1'b0;
    chk("t3_count",    32'(bus.q_count),   32'd0);
    chk("t3_valid",    32'(bus.q_valid),   32'd0);
    chk("t3_drain",    32'(bus.dbg_state), 32'(S_DRAIN));
    chk("t3_req_held", 32'(bus.mem_req),   32'd1);
    chk("t3_old_addr", 32'(bus.mem_addr),  32'h001A);
    chk("t3_fetch_pc", 32'(bus.fetch_pc),  32'h1234);
    tick();
    tick();
    chk("t3_idle",     32'(bus.dbg_state), 32'(S_IDLE));
    chk("t3_req_drop", 32'(bus.mem_req),   32'd0);
    chk("t3_count2",   32'(bus.q_count),   32'd0);
    exp_q.push_back({16'h1234, 8'h34});
    drain_exp("t3_first_byte");
    chk("t3_addrs", 32'(exp_addr_q.size()), 32'd0);
    ack_delay = 1;

    // 4. Flush coincident with mem_ack and an attempted pop at q_count=3.
    wait_full_idle("t4_full");
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'h2000 + 16'(i));
    exp_addr_q.push_back(16'h3000);
    bus.flush  = 1'b1;
    bus.new_pc = 16'h2000;
    tick();
    bus.flush = 1'b0;
    chk("t4_idle_flush_count", 32'(bus.q_count),  32'd0);
    chk("t4_idle_flush_pc",    32'(bus.fetch_pc), 32'h2000);
    n = 0;
    while (!(bus.q_count == 3'd3 && bus.mem_req) && n < 50) begin
      tick();
      n++;
    end
    chk("t4_count3_req", 32'(n < 50), 32'd1);
    tick();
    bus.flush   = 1'b1;
    bus.new_pc  = 16'h3000;
    bus.q_ready = 1'b1;
    tick();
    bus.flush   = 1'b0;
    bus.q_ready = 1'b0;
    chk("t4_count",    32'(bus.q_count),   32'd0);
    chk("t4_valid",    32'(bus.q_valid),   32'd0);
    chk("t4_state",    32'(bus.dbg_state), 32'(S_IDLE));
    chk("t4_req",      32'(bus.mem_req),   32'd0);
    chk("t4_fetch_pc", 32'(bus.fetch_pc),  32'h3000);
    exp_q.push_back({16'h3000, 8'h00});
    drain_exp("t4_first_byte");
    chk("t4_addrs", 32'(exp_addr_q.size()), 32'd0);

    // 5. Address wrap at the top of the address space.
    wait_full_idle("t5_full");
    exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'hFFFF);
    exp_addr_q.push_back(16'h0000);
    exp_q.push_back({16'hFFFE, 8'hFE});
    exp_q.push_back({16'hFFFF, 8'hFF});
    exp_q.push_back({16'h0000, 8'h00});
    bus.flush  = 1'b1;
    bus.new_pc = 16'hFFFE;
    tick();
    bus.flush = 1'b0;
    chk("t5_fetch_pc", 32'(bus.fetch_pc), 32'hFFFE);
    drain_exp("t5_wrap_bytes");
    chk("t5_addrs", 32'(exp_addr_q.size()), 32'd0);

    // 6. Asynchronous reset mid-request.
    n = 0;
    while (!(bus.q_count == 3'd4 && bus.mem_req) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_count4_req", 32'(n < 100), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_mem_req",  32'(bus.mem_req),   32'd0);
    chk("t6_mem_addr", 32'(bus.mem_addr),  32'h0000);
    chk("t6_count",    32'(bus.q_count),   32'd0);
    chk("t6_valid",    32'(bus.q_valid),   32'd0);
    chk("t6_fetch_pc", 32'(bus.fetch_pc),  32'h0000);
    chk("t6_state",    32'(bus.dbg_state), 32'(S_IDLE));
    chk("t6_q_data",   32'(bus.q_data),    32'h00);
    chk("t6_q_pc",     32'(bus.q_pc),      32'h0000);
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    exp_q.push_back({16'h0000, 8'h00});
    exp_q.push_back({16'h0001, 8'h01});
    tick();
    tick();
    rst = 1'b1;
    drain_exp("t6_restart_bytes");
    chk("t6_addrs", 32'(exp_addr_q.size()), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
